fluxo_dados_desafio: RTL and testbench

FLUXO_DADOS_DESAFIO -- requirements
Module: fluxo_dados_desafio

---
 rtl/fluxo_dados_desafio_pkg.sv | 34 +++
 rtl/fluxo_dados_desafio_edge_detector.sv | 24 ++
 rtl/fluxo_dados_desafio.sv | 84 ++++++++
 tb/tb_fluxo_dados_desafio.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fluxo_dados_desafio_pkg.sv
// rtl/fluxo_dados_desafio_pkg.sv - shared widths, timer default and play memory table
package fluxo_dados_desafio_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 4;
  localparam int TIMEOUT_CYCLES_DEFAULT = 5000;

  // Expected play sequence: one-hot button per round.
  function automatic logic [DATA_W-1:0] mem_read(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] word;
    word = 4'h1;
    case (addr)
      4'd0:  word = 4'h1;
      4'd1:  word = 4'h2;
      4'd2:  word = 4'h4;
      4'd3:  word = 4'h8;
      4'd4:  word = 4'h4;
      4'd5:  word = 4'h2;
      4'd6:  word = 4'h1;
      4'd7:  word = 4'h1;
      4'd8:  word = 4'h2;
      4'd9:  word = 4'h2;
      4'd10: word = 4'h4;
      4'd11: word = 4'h4;
      4'd12: word = 4'h8;
      4'd13: word = 4'h1;
      4'd14: word = 4'h8;
      4'd15: word = 4'h4;
      default: word = 4'h1;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/fluxo_dados_desafio_edge_detector.sv
// rtl/fluxo_dados_desafio_edge_detector.sv - one-cycle pulse on rising edge of sinal
module edge_detector (
  input  logic clock,
  input  logic reset,
  input  logic sinal,
  output logic pulso
);

  logic s1;
  logic s2;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= sinal;
      s2 <= s1;
    end
  end

  assign pulso = s1 & ~s2;

endmodule

// File: rtl/fluxo_dados_desafio.sv
// rtl/fluxo_dados_desafio.sv - game datapath: address counter, play register, memory, press detect, play timer
module fluxo_dados_desafio
  import fluxo_dados_desafio_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              zeraC,
  input  logic              contaC,
  input  logic              zeraR,
  input  logic              registraR,
  input  logic              zera_timer,
  input  logic              conta_timer,
  input  logic [DATA_W-1:0] botoes,
  output logic              fim,
  output logic              igual,
  output logic              jogada_feita,
  output logic              fim_timer,
  output logic [ADDR_W-1:0] db_contagem,
  output logic [DATA_W-1:0] db_jogada,
  output logic [DATA_W-1:0] db_memoria,
  output logic              db_tem_jogada
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

  logic [ADDR_W-1:0] contagem;
  logic [DATA_W-1:0] jogada;
  logic [DATA_W-1:0] memoria;
  logic [TW-1:0]     timer;
  logic              tem_jogada;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      contagem <= '0;
    end else if (zeraC) begin
      contagem <= '0;
    end else if (contaC) begin
      contagem <= contagem + 4'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      jogada <= '0;
    end else if (zeraR) begin
      jogada <= '0;
    end else if (registraR) begin
      jogada <= botoes;
    end
  end

  // Saturates so fim_timer stays asserted until the controller clears it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer <= '0;
    end else if (zera_timer) begin
      timer <= '0;
    end else if (conta_timer && (timer != TIMER_MAX)) begin
      timer <= timer + TW'(1);
    end
  end

  assign memoria    = mem_read(contagem);
  assign tem_jogada = |botoes;

  edge_detector u_edge_detector (
    .clock (clock),
    .reset (reset),
    .sinal (tem_jogada),
    .pulso (jogada_feita)
  );

  assign fim           = (contagem == 4'd15);
  assign igual         = (jogada == memoria);
  assign fim_timer     = (timer == TIMER_MAX);
  assign db_contagem   = contagem;
  assign db_jogada     = jogada;
  assign db_memoria    = memoria;
  assign db_tem_jogada = tem_jogada;

endmodule

// File: tb/tb_fluxo_dados_desafio.sv
// tb/tb_fluxo_dados_desafio.sv - self-checking bench for fluxo_dados_desafio (TIMEOUT_CYCLES=10)
module tb_fluxo_dados_desafio;

  logic       clock = 1'b0;
  logic       reset;
  logic       zeraC, contaC, zeraR, registraR, zera_timer, conta_timer;
  logic [3:0] botoes;
  logic       fim, igual, jogada_feita, fim_timer, db_tem_jogada;
  logic [3:0] db_contagem, db_jogada, db_memoria;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] cont, jog, mem;
    logic       fim, igual, jf, tem, fimt;
  } out_t;

  typedef struct {
    logic       zc, cc, zr, rr;
    logic [3:0] bot;
    out_t       exp;
  } vec_t;

  out_t       sb[$];
  vec_t       vecs[12];
  logic [3:0] mem_ref[16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
                              4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h1, 4'h8, 4'h4};

  fluxo_dados_desafio #(.TIMEOUT_CYCLES(10)) dut (
    .clock         (clock),
    .reset         (reset),
    .zeraC         (zeraC),
    .contaC        (contaC),
    .zeraR         (zeraR),
    .registraR     (registraR),
    .zera_timer    (zera_timer),
    .conta_timer   (conta_timer),
    .botoes        (botoes),
    .fim           (fim),
    .igual         (igual),
    .jogada_feita  (jogada_feita),
    .fim_timer     (fim_timer),
    .db_contagem   (db_contagem),
    .db_jogada     (db_jogada),
    .db_memoria    (db_memoria),
    .db_tem_jogada (db_tem_jogada)
  );

  always #5 clock = ~clock;

  function automatic out_t mk(logic [3:0] cont, logic [3:0] jog, logic [3:0] mem, logic f,
                              logic ig, logic jf, logic tem, logic fimt);
    out_t o;
    o.cont = cont; o.jog = jog; o.mem = mem; o.fim = f;
    o.igual = ig; o.jf = jf; o.tem = tem; o.fimt = fimt;
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input out_t e);
    check({tag, ".db_contagem"},   32'(db_contagem),   32'(e.cont));
    check({tag, ".db_jogada"},     32'(db_jogada),     32'(e.jog));
    check({tag, ".db_memoria"},    32'(db_memoria),    32'(e.mem));
    check({tag, ".fim"},           32'(fim),           32'(e.fim));
    check({tag, ".igual"},         32'(igual),         32'(e.igual));
    check({tag, ".jogada_feita"},  32'(jogada_feita),  32'(e.jf));
    check({tag, ".db_tem_jogada"}, 32'(db_tem_jogada), 32'(e.tem));
    check({tag, ".fim_timer"},     32'(fim_timer),     32'(e.fimt));
  endtask

  task automatic drive(input logic zc, input logic cc, input logic zr, input logic rr,
                       input logic zt, input logic ct, input logic [3:0] bot);
    zeraC = zc; contaC = cc; zeraR = zr; registraR = rr;
    zera_timer = zt; conta_timer = ct; botoes = bot;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sb_compare(input string tag);
    out_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got jogada_feita=%0b expected an entry", tag, jogada_feita);
    end else begin
      e = sb.pop_front();
      check_all(tag, e);
    end
  endtask

  // Drive one step, record the expectation, then compare after the edge.
  task automatic sb_step(input string tag, input logic zc, input logic cc, input logic zr,
                         input logic rr, input logic [3:0] bot, input out_t e);
    drive(zc, cc, zr, rr, 1'b0, 1'b0, bot);
    sb.push_back(e);
    tick();
    sb_compare(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{0,0,0,0, 4'h0, mk(4'd0, 4'h0, 4'h1, 0,0,0,0,0)};
    vecs[1]  = '{0,0,0,1, 4'h1, mk(4'd0, 4'h1, 4'h1, 0,1,1,1,0)};
    vecs[2]  = '{0,1,0,0, 4'h1, mk(4'd1, 4'h1, 4'h2, 0,0,0,1,0)};
    vecs[3]  = '{0,0,0,1, 4'h2, mk(4'd1, 4'h2, 4'h2, 0,1,0,1,0)};
    vecs[4]  = '{1,1,0,0, 4'h0, mk(4'd0, 4'h2, 4'h1, 0,0,0,0,0)};
    vecs[5]  = '{0,0,1,1, 4'h4, mk(4'd0, 4'h0, 4'h1, 0,0,1,1,0)};
    vecs[6]  = '{0,1,0,0, 4'h4, mk(4'd1, 4'h0, 4'h2, 0,0,0,1,0)};
    vecs[7]  = '{0,1,0,0, 4'h4, mk(4'd2, 4'h0, 4'h4, 0,0,0,1,0)};
    vecs[8]  = '{0,1,0,0, 4'h4, mk(4'd3, 4'h0, 4'h8, 0,0,0,1,0)};
    vecs[9]  = '{0,0,0,1, 4'h4, mk(4'd3, 4'h4, 4'h8, 0,0,0,1,0)};
    vecs[10] = '{0,0,0,1, 4'h8, mk(4'd3, 4'h8, 4'h8, 0,1,0,1,0)};
    vecs[11] = '{1,1,0,0, 4'h0, mk(4'd0, 4'h8, 4'h1, 0,0,0,0,0)};

    // Reset state, held across edges.
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 4'h0);
    tick();
    tick();
    check_all("reset", mk(4'd0, 4'h0, 4'h1, 0, 0, 0, 0, 0));
    reset = 1'b0;
    sb_step("clear", 1, 0, 1, 0, 4'h0, mk(4'd0, 4'h0, 4'h1, 0, 0, 0, 0, 0));

    for (int i = 0; i < 12; i++)
      sb_step($sformatf("vec%0d", i), vecs[i].zc, vecs[i].cc, vecs[i].zr, vecs[i].rr,
              vecs[i].bot, vecs[i].exp);

    // Long press gives one pulse; registering it matches memory[0].
    sb_step("pre_hold", 1, 0, 1, 0, 4'h0, mk(4'd0, 4'h0, 4'h1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 20; i++)
      sb_step($sformatf("hold%0d", i), 0, 0, 0, 0, 4'h1,
              mk(4'd0, 4'h0, 4'h1, 0, 0, (i == 0), 1, 0));
    sb_step("hold_reg", 0, 0, 0, 1, 4'h1, mk(4'd0, 4'h1, 4'h1, 0, 1, 0, 1, 0));
    sb_step("release0", 0, 0, 0, 0, 4'h0, mk(4'd0, 4'h1, 4'h1, 0, 1, 0, 0, 0));
    sb_step("release1", 0, 0, 0, 0, 4'h0, mk(4'd0, 4'h1, 4'h1, 0, 1, 0, 0, 0));
    sb_step("repress", 0, 0, 0, 0, 4'h2, mk(4'd0, 4'h1, 4'h1, 0, 1, 1, 1, 0));
    sb_step("repress_hold", 0, 0, 0, 0, 4'h2, mk(4'd0, 4'h1, 4'h1, 0, 1, 0, 1, 0));

    // Full address sweep with wrap.
    drive(1, 0, 0, 0, 0, 0, 4'h0);
    tick();
    check("sweep_start.db_contagem", 32'(db_contagem), 32'd0);
    for (int i = 1; i <= 16; i++) begin
      drive(0, 1, 0, 0, 0, 0, 4'h0);
      tick();
      check($sformatf("sweep%0d.db_contagem", i), 32'(db_contagem), 32'(i % 16));
      check($sformatf("sweep%0d.fim", i), 32'(fim), 32'((i % 16) == 15));
      check($sformatf("sweep%0d.db_memoria", i), 32'(db_memoria), 32'(mem_ref[i % 16]));
    end

    // Timer: expires after 9 counting edges and saturates.
    drive(0, 0, 0, 0, 1, 0, 4'h0);
    tick();
    check("timer_clear.fim_timer", 32'(fim_timer), 32'd0);
    for (int k = 1; k <= 12; k++) begin
      drive(0, 0, 0, 0, 0, 1, 4'h0);
      tick();
      check($sformatf("timer%0d.fim_timer", k), 32'(fim_timer), 32'(k >= 9));
    end
    drive(0, 0, 0, 0, 1, 1, 4'h0);
    tick();
    check("timer_zera.fim_timer", 32'(fim_timer), 32'd0);
    for (int k = 1; k <= 12; k++) begin
      drive(0, 0, 0, 0, 0, (k <= 5) || (k > 8), 4'h0);
      tick();
      check($sformatf("timer_hold%0d.fim_timer", k), 32'(fim_timer), 32'(k >= 12));
    end

    // Asynchronous reset mid-cycle with address 7, timer 5, button held.
    drive(1, 0, 0, 0, 1, 0, 4'h0);
    tick();
    for (int k = 0; k < 7; k++) begin
      drive(0, 1, 0, 0, 0, (k < 5), 4'h0);
      tick();
    end
    drive(0, 0, 0, 1, 0, 0, 4'h2);
    tick();
    check("pre_reset.db_contagem", 32'(db_contagem), 32'd7);
    check("pre_reset.db_jogada", 32'(db_jogada), 32'h2);
    drive(0, 0, 0, 0, 0, 0, 4'h2);
    #2;
    reset = 1'b1;
    #1;
    check_all("async_reset", mk(4'd0, 4'h0, 4'h1, 0, 0, 0, 1, 0));
    tick();
    check("in_reset.jogada_feita", 32'(jogada_feita), 32'd0);
    reset = 1'b0;
    tick();
    check("post_reset.jogada_feita", 32'(jogada_feita), 32'd1);
    tick();
    check("post_reset2.jogada_feita", 32'(jogada_feita), 32'd0);
    for (int k = 1; k <= 9; k++) begin
      drive(0, 0, 0, 0, 0, 1, 4'h0);
      tick();
      check($sformatf("post_reset_timer%0d.fim_timer", k), 32'(fim_timer), 32'(k == 9));
    end

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
